// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the timer control sequencer:
//   DIV_VAL_MAX   - largest legal divider select
//   cfg_state_e   - configuration FSM states
//   halt_state_e  - debug-halt handshake FSM states
//   timer_cfg_t   - one complete live/shadow counter configuration
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam logic [3:0] DIV_VAL_MAX = 4'd8;

    typedef enum logic {
        C_IDLE,
        C_WAIT
    } cfg_state_e;

    typedef enum logic [1:0] {
        H_IDLE,
        H_REQ,
        H_HALT
    } halt_state_e;

    typedef struct packed {
        logic       timer_en;
        logic       div_en;
        logic [3:0] div_val;
    } timer_cfg_t;

endpackage

// File: rtl/timer_halt_fsm.sv
// -----------------------------------------------------------------------------
// timer_halt_fsm
// Debug-halt handshake towards the counter control block. A level halt request
// from the debugger (only honoured in debug mode) raises halt_req; the counter
// control acknowledges once it has frozen, after which halted is reported.
// Ports:
//   sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//   dbg_mode_i          - debug mode; dropping it abandons any halt at once
//   dbg_halt_in_i       - level halt request from the debugger
//   halt_ack_i          - counter control has frozen
//   halt_req_o          - registered request to counter control
//   halted_o            - registered "counter is frozen" status
// -----------------------------------------------------------------------------
module timer_halt_fsm
    import timer_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic dbg_mode_i,
    input  logic dbg_halt_in_i,
    input  logic halt_ack_i,
    output logic halt_req_o,
    output logic halted_o
);

    halt_state_e state_q, state_d;
    logic        halt_req_q;
    logic        halted_q;

    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for state_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            H_IDLE: if (dbg_halt_in_i && dbg_mode_i) state_d = H_REQ;
            H_REQ: begin
                if (!dbg_mode_i)     state_d = H_IDLE;
                else if (halt_ack_i) state_d = H_HALT;
            end
            H_HALT: if (!dbg_mode_i || !dbg_halt_in_i) state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state itself while still coming straight out of flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= H_IDLE;
            halt_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_req_q <= (state_d != H_IDLE);
            halted_q   <= (state_d == H_HALT);
        end
    end

    assign halt_req_o = halt_req_q;
    assign halted_o   = halted_q;

endmodule

// File: rtl/timer_ctrl_seq.sv
// -----------------------------------------------------------------------------
// timer_ctrl_seq
// Owns the live timer_en/div_en/div_val configuration of the 64-bit timer and
// applies software writes without breaking the prescaler phase: a running
// divider only changes at a period boundary (cnt_en=1), with a timeout that
// forces the update if no boundary arrives. Also hosts the debug-halt FSM.
// Ports:
//   sys_clk, sys_rst_n           - clock, asynchronous active-low reset
//   cfg_wr, cfg_timer_en,
//   cfg_div_en, cfg_div_val      - single-cycle configuration write
//   cfg_busy                     - an update is pending a boundary
//   cfg_err                      - 1-cycle pulse, write rejected
//   upd_done                     - 1-cycle pulse, new config live this cycle
//   timer_en, div_en, div_val    - live configuration to counter control
//   dbg_mode, dbg_halt_in        - debugger controls
//   halt_ack, cnt_en             - status from counter control
//   halt_req, halted             - halt handshake outputs
// MAX_WAIT must exceed 256 (longest prescaler period) and fit in WAIT_W bits.
// -----------------------------------------------------------------------------
module timer_ctrl_seq
    import timer_pkg::*;
#(
    parameter int MAX_WAIT = 300,
    parameter int WAIT_W   = 9
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_wr,
    input  logic       cfg_timer_en,
    input  logic       cfg_div_en,
    input  logic [3:0] cfg_div_val,
    output logic       cfg_busy,
    output logic       cfg_err,
    output logic       upd_done,
    output logic       timer_en,
    output logic       div_en,
    output logic [3:0] div_val,
    input  logic       dbg_mode,
    input  logic       dbg_halt_in,
    input  logic       halt_ack,
    input  logic       cnt_en,
    output logic       halt_req,
    output logic       halted
);

    cfg_state_e        state_q, state_d;
    timer_cfg_t        live_q, live_d;
    timer_cfg_t        shadow_q, shadow_d;
    timer_cfg_t        wr_cfg;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              busy_q;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              boundary;
    logic              timeout;
    logic              apply_now;

    timer_halt_fsm u_halt (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .dbg_mode_i    (dbg_mode),
        .dbg_halt_in_i (dbg_halt_in),
        .halt_ack_i    (halt_ack),
        .halt_req_o    (halt_req),
        .halted_o      (halted)
    );

    assign wr_cfg   = '{cfg_timer_en, cfg_div_en, cfg_div_val};
    // A tick from a frozen counter is not a real period boundary.
    assign boundary = cnt_en && !halted;
    // The wait counter would reach MAX_WAIT on this edge; apply together.
    assign timeout  = !halted && (wait_q == WAIT_W'(MAX_WAIT - 1));
    // Nothing to protect when stopping, when the timer/prescaler is idle,
    // or when this very cycle is a boundary.
    assign apply_now = !cfg_timer_en || !live_q.timer_en || !live_q.div_en
                       || boundary;

    always_comb begin
        state_d  = state_q;
        live_d   = live_q;
        shadow_d = shadow_q;
        wait_d   = wait_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (cfg_wr) begin
                    if (cfg_div_val > DIV_VAL_MAX) begin
                        err_d = 1'b1;
                    end else if (apply_now) begin
                        live_d = wr_cfg;
                        done_d = 1'b1;
                    end else begin
                        shadow_d = wr_cfg;
                        wait_d   = '0;
                        state_d  = C_WAIT;
                    end
                end
            end
            C_WAIT: begin
                if (cfg_wr && !cfg_timer_en) begin
                    // Stop overrides the pending update.
                    live_d  = wr_cfg;
                    done_d  = 1'b1;
                    state_d = C_IDLE;
                end else begin
                    err_d = cfg_wr;
                    if (boundary || timeout) begin
                        live_d  = shadow_q;
                        done_d  = 1'b1;
                        state_d = C_IDLE;
                    end else if (!halted) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    // NOTE: the shadow registers are reset too even though they are only read
    // after being loaded; it keeps the block free of X after reset at the cost
    // of a few reset-capable flops.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= C_IDLE;
            live_q   <= '0;
            shadow_q <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            shadow_q <= shadow_d;
            wait_q   <= wait_d;
            busy_q   <= (state_d == C_WAIT);
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign cfg_busy = busy_q;
    assign cfg_err  = err_q;
    assign upd_done = done_q;
    assign timer_en = live_q.timer_en;
    assign div_en   = live_q.div_en;
    assign div_val  = live_q.div_val;

endmodule

// File: tb/tb_timer_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl_seq
// Directed scenarios plus a randomized run against a behavioural model of the
// sequencer. A small prescaler model stands in for the counter control block:
// period 2^div_val when div_en=1, frozen while halted.
// -----------------------------------------------------------------------------
module tb_timer_ctrl_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cfg_wr = 1'b0;
    logic       cfg_timer_en = 1'b0;
    logic       cfg_div_en = 1'b0;
    logic [3:0] cfg_div_val = 4'd0;
    logic       cfg_busy, cfg_err, upd_done;
    logic       timer_en, div_en;
    logic [3:0] div_val;
    logic       dbg_mode = 1'b0;
    logic       dbg_halt_in = 1'b0;
    logic       halt_ack, cnt_en;
    logic       halt_req, halted;

    // Source selection for the counter-control side signals.
    logic cnt_sel = 1'b0, cnt_force = 1'b0;
    logic ack_sel = 1'b0, ack_force = 1'b0;
    int   pre_cnt;
    logic model_tick;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    timer_ctrl_seq #(.MAX_WAIT(300), .WAIT_W(9)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cfg_wr       (cfg_wr),
        .cfg_timer_en (cfg_timer_en),
        .cfg_div_en   (cfg_div_en),
        .cfg_div_val  (cfg_div_val),
        .cfg_busy     (cfg_busy),
        .cfg_err      (cfg_err),
        .upd_done     (upd_done),
        .timer_en     (timer_en),
        .div_en       (div_en),
        .div_val      (div_val),
        .dbg_mode     (dbg_mode),
        .dbg_halt_in  (dbg_halt_in),
        .halt_ack     (halt_ack),
        .cnt_en       (cnt_en),
        .halt_req     (halt_req),
        .halted       (halted)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Prescaler stand-in: wraps on every tick, restarts from 0 when idle.
    assign model_tick = timer_en && !halted && (!div_en || pre_cnt == (1 << div_val) - 1);
    assign cnt_en     = cnt_sel ? cnt_force : model_tick;
    assign halt_ack   = ack_sel ? ack_force : halt_req;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                          pre_cnt <= 0;
        else if (!timer_en || halted || model_tick) pre_cnt <= 0;
        else                                     pre_cnt <= pre_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    // Output vector: {timer_en, div_en, div_val, busy, err, done, halt_req, halted}
    function automatic logic [10:0] outs();
        return {timer_en, div_en, div_val, cfg_busy, cfg_err, upd_done, halt_req, halted};
    endfunction

    function automatic logic [10:0] ev(input bit te, input bit de, input logic [3:0] dv,
                                       input bit bz, input bit er, input bit dn,
                                       input bit hr, input bit hl);
        return {te, de, dv, bz, er, dn, hr, hl};
    endfunction

    // Called at a negedge; returns at the negedge where the write's effect shows.
    task automatic do_write(input bit t, input bit d, input logic [3:0] v);
        cfg_wr = 1'b1; cfg_timer_en = t; cfg_div_en = d; cfg_div_val = v;
        @(negedge sys_clk);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_tick(input string name, input int budget);
        int n = 0;
        while (!cnt_en && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        n_cmp++;
        if (cnt_en !== 1'b1) begin
            n_mis++;
            $display("FAIL %s: cnt_en got %b after %0d cycles, required 1", name, cnt_en, budget);
        end
    endtask

    task automatic test_reset();
        logic [10:0] o;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== 11'd0) begin n_mis++; $display("FAIL reset_hold: got %b required %b", o, 11'd0); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== 11'd0) begin n_mis++; $display("FAIL reset_release: got %b required %b", o, 11'd0); end
    endtask

    task automatic test_immediate();
        logic [10:0] o;
        int busy_seen = 0;
        do_write(1, 1, 4'd2);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,2,0,0,1,0,0)) begin n_mis++; $display("FAIL imm_apply: got %b required %b", o, ev(1,1,2,0,0,1,0,0)); end
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,2,0,0,0,0,0)) begin n_mis++; $display("FAIL imm_done_pulse: got %b required %b", o, ev(1,1,2,0,0,0,0,0)); end
        repeat (8) begin
            @(negedge sys_clk);
            if (cfg_busy !== 1'b0) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0) begin n_mis++; $display("FAIL imm_busy: busy cycles got %0d required 0", busy_seen); end
    endtask

    task automatic test_deferred_period();
        logic [10:0] o;
        int t0, t_prev, t_b, n, bad;
        do_write(0, 0, 4'd0);
        do_write(1, 1, 4'd3);
        wait_tick("period_sync", 20);
        t0 = cyc;
        @(negedge sys_clk);
        wait_tick("period_old", 20);
        n_cmp++;
        if (cyc - t0 != 8) begin n_mis++; $display("FAIL period_old: got %0d required 8", cyc - t0); end
        t_prev = cyc;
        @(negedge sys_clk);
        do_write(1, 1, 4'd1);
        n = 0; bad = 0;
        while (!cnt_en && n < 20) begin
            if (outs() !== ev(1,1,3,1,0,0,0,0)) bad++;
            @(negedge sys_clk);
            n++;
        end
        n_cmp++;
        if (bad != 0) begin n_mis++; $display("FAIL defer_hold: bad cycles got %0d required 0", bad); end
        wait_tick("defer_boundary", 1);
        t_b = cyc;
        n_cmp++;
        if (t_b - t_prev != 8) begin n_mis++; $display("FAIL no_short_period: got %0d required 8", t_b - t_prev); end
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,1,0,0,1,0,0)) begin n_mis++; $display("FAIL defer_apply: got %b required %b", o, ev(1,1,1,0,0,1,0,0)); end
        wait_tick("period_new", 20);
        n_cmp++;
        if (cyc - t_b != 2) begin n_mis++; $display("FAIL period_new: got %0d required 2", cyc - t_b); end
    endtask

    task automatic test_illegal();
        logic [10:0] o;
        @(negedge sys_clk);
        do_write(1, 1, 4'd9);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,1,0,1,0,0,0)) begin n_mis++; $display("FAIL illegal_idle: got %b required %b", o, ev(1,1,1,0,1,0,0,0)); end
        @(negedge sys_clk);
        n_cmp++;
        if (cfg_err !== 1'b0) begin n_mis++; $display("FAIL err_pulse_width: got %b required 0", cfg_err); end
        do_write(0, 0, 4'd0);
        do_write(1, 1, 4'd3);
        do_write(1, 1, 4'd2);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,3,1,0,0,0,0)) begin n_mis++; $display("FAIL wait_enter: got %b required %b", o, ev(1,1,3,1,0,0,0,0)); end
        do_write(1, 1, 4'd4);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,3,1,1,0,0,0)) begin n_mis++; $display("FAIL wait_reject: got %b required %b", o, ev(1,1,3,1,1,0,0,0)); end
        wait_tick("reject_boundary", 20);
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,2,0,0,1,0,0)) begin n_mis++; $display("FAIL pending_kept: got %b required %b", o, ev(1,1,2,0,0,1,0,0)); end
    endtask

    task automatic test_stop_in_wait();
        logic [10:0] o;
        do_write(0, 0, 4'd0);
        do_write(1, 1, 4'd8);
        do_write(1, 1, 4'd5);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,8,1,0,0,0,0)) begin n_mis++; $display("FAIL stop_pending: got %b required %b", o, ev(1,1,8,1,0,0,0,0)); end
        repeat (10) @(negedge sys_clk);
        do_write(0, 1, 4'd5);
        o = outs();
        n_cmp++;
        if (o !== ev(0,1,5,0,0,1,0,0)) begin n_mis++; $display("FAIL stop_apply: got %b required %b", o, ev(0,1,5,0,0,1,0,0)); end
    endtask

    task automatic test_halt();
        logic [10:0] o;
        int bad = 0;
        dbg_mode = 1'b1;
        do_write(0, 0, 4'd0);
        do_write(1, 1, 4'd3);
        dbg_halt_in = 1'b1;
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,3,0,0,0,1,0)) begin n_mis++; $display("FAIL halt_req_lat: got %b required %b", o, ev(1,1,3,0,0,0,1,0)); end
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,3,0,0,0,1,1)) begin n_mis++; $display("FAIL halted_lat: got %b required %b", o, ev(1,1,3,0,0,0,1,1)); end
        do_write(1, 1, 4'd1);
        repeat (500) begin
            if (outs() !== ev(1,1,3,1,0,0,1,1)) bad++;
            @(negedge sys_clk);
        end
        n_cmp++;
        if (bad != 0) begin n_mis++; $display("FAIL halt_freeze: bad cycles got %0d required 0", bad); end
        dbg_halt_in = 1'b0;
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,3,1,0,0,0,0)) begin n_mis++; $display("FAIL halt_release: got %b required %b", o, ev(1,1,3,1,0,0,0,0)); end
        wait_tick("release_boundary", 20);
        @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,1,0,0,1,0,0)) begin n_mis++; $display("FAIL release_apply: got %b required %b", o, ev(1,1,1,0,0,1,0,0)); end
        dbg_halt_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        dbg_mode = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if ({halt_req, halted} !== 2'b00) begin n_mis++; $display("FAIL dbg_mode_drop: got %b required 00", {halt_req, halted}); end
        dbg_halt_in = 1'b0;
        dbg_mode = 1'b1;
    endtask

    task automatic test_timeout_reset();
        logic [10:0] o;
        int first_k = -1;
        do_write(0, 0, 4'd0);
        do_write(1, 1, 4'd3);
        cnt_sel = 1'b1; cnt_force = 1'b0;
        do_write(1, 1, 4'd6);
        for (int k = 1; k <= 310 && first_k < 0; k++) begin
            @(negedge sys_clk);
            if (upd_done === 1'b1) first_k = k;
        end
        n_cmp++;
        if (first_k != 300) begin n_mis++; $display("FAIL timeout_latency: got %0d required 300", first_k); end
        o = outs();
        n_cmp++;
        if (o !== ev(1,1,6,0,0,1,0,0)) begin n_mis++; $display("FAIL timeout_apply: got %b required %b", o, ev(1,1,6,0,0,1,0,0)); end
        do_write(1, 1, 4'd2);
        repeat (50) @(negedge sys_clk);
        n_cmp++;
        if (cfg_busy !== 1'b1) begin n_mis++; $display("FAIL mid_wait_busy: got %b required 1", cfg_busy); end
        sys_rst_n = 1'b0;
        #1;
        o = outs();
        n_cmp++;
        if (o !== 11'd0) begin n_mis++; $display("FAIL mid_reset: got %b required %b", o, 11'd0); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        o = outs();
        n_cmp++;
        if (o !== 11'd0) begin n_mis++; $display("FAIL pending_dropped: got %b required %b", o, 11'd0); end
        cnt_sel = 1'b0;
    endtask

    // Behavioural reference: configuration, pending request, unhalted age.
    typedef struct {
        bit       te;
        bit       de;
        bit [3:0] dv;
    } mcfg_t;

    mcfg_t m_live, m_shadow;
    bit    m_pend, m_err, m_done, m_req, m_hlt;
    int    m_age;

    task automatic model_step(input bit wr, input mcfg_t c, input bit dm, input bit dh,
                              input bit ack, input bit ce);
        bit frozen = m_hlt;
        bit real_tick = ce && !frozen;
        m_err = 0;
        m_done = 0;
        if (!m_pend) begin
            if (wr) begin
                if (c.dv > 8) m_err = 1;
                else if (!c.te || !m_live.te || !m_live.de || real_tick) begin
                    m_live = c; m_done = 1;
                end else begin
                    m_pend = 1; m_shadow = c; m_age = 0;
                end
            end
        end else if (wr && !c.te) begin
            m_live = c; m_done = 1; m_pend = 0;
        end else begin
            if (wr) m_err = 1;
            if (!frozen) m_age++;
            if (real_tick || m_age == 300) begin
                m_live = m_shadow; m_done = 1; m_pend = 0;
            end
        end
        // Halt handshake
        if ((m_req || m_hlt) && !dm) begin
            m_req = 0; m_hlt = 0;
        end else if (!m_req) begin
            if (dh && dm) m_req = 1;
        end else if (!m_hlt) begin
            if (ack) m_hlt = 1;
        end else if (!dh) begin
            m_req = 0; m_hlt = 0;
        end
    endtask

    task automatic test_random();
        logic [10:0] o, e;
        mcfg_t c;
        bit w;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt_sel = 1'b1; ack_sel = 1'b1;
        m_live = '{0, 0, 4'd0}; m_shadow = '{0, 0, 4'd0};
        m_pend = 0; m_err = 0; m_done = 0; m_req = 0; m_hlt = 0; m_age = 0;
        for (int i = 0; i < 3000; i++) begin
            o = outs();
            e = {m_live.te, m_live.de, m_live.dv, m_pend, m_err, m_done, m_req, m_hlt};
            n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL random[%0d]: got %b required %b", i, o, e); end
            w = ($urandom_range(0, 3) == 0);
            c.te = ($urandom_range(0, 9) != 0);
            c.de = ($urandom_range(0, 4) != 0);
            c.dv = 4'($urandom_range(0, 10));
            cfg_wr = w; cfg_timer_en = c.te; cfg_div_en = c.de; cfg_div_val = c.dv;
            dbg_mode = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) dbg_halt_in = ~dbg_halt_in;
            cnt_force = ($urandom_range(0, 3) == 0);
            ack_force = ($urandom_range(0, 1) == 1);
            model_step(w, c, dbg_mode, dbg_halt_in, ack_force, cnt_force);
            @(negedge sys_clk);
        end
        cfg_wr = 1'b0;
        cnt_sel = 1'b0; ack_sel = 1'b0;
        dbg_halt_in = 1'b0;
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_immediate();
        test_deferred_period();
        test_illegal();
        test_stop_in_wait();
        test_halt();
        test_timeout_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
